// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - Arbitrated nibble-serial wide adder sequencer driving a shared external adder slice
module multiword_add_ctrl #(
    parameter  int SLICE_W    = 4,
    parameter  int NUM_SLICES = 4,
    localparam int OP_W       = SLICE_W * NUM_SLICES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    input  logic              req1_cin,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OP_W-1:0]   res_sum,
    output logic              res_cout,
    output logic              res_id,
    output logic [SLICE_W-1:0] slc_a,
    output logic [SLICE_W-1:0] slc_b,
    output logic              slc_cin,
    input  logic [SLICE_W-1:0] slc_sum,
    input  logic              slc_cout
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    stateT            nextState;
    logic [OP_W-1:0]  opA;
    logic [OP_W-1:0]  opB;
    logic [OP_W-1:0]  sumReg;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             ownerId;
    logic             lastGrant;
    logic             grant;
    logic             anyValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        anyValid   = req0_valid | req1_valid;
        // On a tie the requester that lost last time wins
        grant      = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~lastGrant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        slc_a      = '0;
        slc_b      = '0;
        slc_cin    = 1'b0;
        res_valid  = 1'b0;
        res_sum    = '0;
        res_cout   = 1'b0;
        res_id     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = anyValid && !grant;
                req1_ready = anyValid && grant;
                if (anyValid) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                slc_a   = opA[idx*SLICE_W +: SLICE_W];
                slc_b   = opB[idx*SLICE_W +: SLICE_W];
                slc_cin = carry;
                if (idx == LAST_IDX) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_sum   = sumReg;
                res_cout  = carry;
                res_id    = ownerId;
                if (res_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA       <= '0;
            opB       <= '0;
            sumReg    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            ownerId   <= 1'b0;
            lastGrant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        opA       <= grant ? req1_a : req0_a;
                        opB       <= grant ? req1_b : req0_b;
                        carry     <= grant ? req1_cin : req0_cin;
                        idx       <= '0;
                        ownerId   <= grant;
                        lastGrant <= grant;
                    end
                end
                RUN: begin
                    // The slice answers combinationally in the same cycle
                    sumReg[idx*SLICE_W +: SLICE_W] <= slc_sum;
                    carry <= slc_cout;
                    idx   <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb/tb_multiword_add_ctrl.sv - Randomized, model-checked bench for multiword_add_ctrl
module tb_multiword_add_ctrl;

    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 4;
    localparam int OP_W       = SLICE_W * NUM_SLICES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req0_cin;
    logic              req1_valid, req1_ready, req1_cin;
    logic [OP_W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic              res_valid, res_ready, res_cout, res_id;
    logic [OP_W-1:0]   res_sum;
    logic [SLICE_W-1:0] slc_a, slc_b, slc_sum;
    logic              slc_cin, slc_cout;
    logic [SLICE_W:0]  sliceFull;

    multiword_add_ctrl #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
        .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin), .slc_sum(slc_sum), .slc_cout(slc_cout)
    );

    // External 4-bit ripple slice
    assign sliceFull = {1'b0, slc_a} + {1'b0, slc_b} + {{SLICE_W{1'b0}}, slc_cin};
    assign slc_sum   = sliceFull[SLICE_W-1:0];
    assign slc_cout  = sliceFull[SLICE_W];

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edgeCount = 0;
    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: one job at a time, result visible NUM_SLICES edges after accept
    bit          jobActive = 0;
    bit          lastG = 1;
    logic [15:0] jobA, jobB;
    logic        jobCin, jobId;
    int          acceptEdge, k, mask, total;
    logic        eR0, eR1, eV, eCin;
    logic [3:0]  eA, eB;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            jobActive = 0;
            lastG = 1;
        end
        eR0 = 0; eR1 = 0; eV = 0; eA = 0; eB = 0; eCin = 0; total = 0;
        if (!jobActive) begin
            eR0 = req0_valid && (!req1_valid || lastG);
            eR1 = req1_valid && (!req0_valid || !lastG);
        end else begin
            k = edgeCount - acceptEdge;
            if (k < NUM_SLICES) begin
                mask = (1 << (4 * k)) - 1;
                eA   = 4'(int'(jobA) >> (4 * k));
                eB   = 4'(int'(jobB) >> (4 * k));
                eCin = 1'(((int'(jobA) & mask) + (int'(jobB) & mask) + int'(jobCin)) >> (4 * k));
            end else begin
                eV    = 1;
                total = int'(jobA) + int'(jobB) + int'(jobCin);
            end
        end
        check("req0_ready", 32'(req0_ready), 32'(eR0));
        check("req1_ready", 32'(req1_ready), 32'(eR1));
        check("res_valid", 32'(res_valid), 32'(eV));
        check("slc_a", 32'(slc_a), 32'(eA));
        check("slc_b", 32'(slc_b), 32'(eB));
        check("slc_cin", 32'(slc_cin), 32'(eCin));
        if (eV) begin
            check("res_sum", 32'(res_sum), 32'(total & 32'hFFFF));
            check("res_cout", 32'(res_cout), 32'((total >> 16) & 1));
            check("res_id", 32'(res_id), 32'(jobId));
        end
        if (!rst_n) begin
            check("rst_res_sum", 32'(res_sum), 32'd0);
            check("rst_res_cout", 32'(res_cout), 32'd0);
            check("rst_res_id", 32'(res_id), 32'd0);
        end else if (!jobActive) begin
            if (req0_valid && eR0) begin
                jobActive = 1; jobA = req0_a; jobB = req0_b; jobCin = req0_cin; jobId = 0;
                lastG = 0; acceptEdge = edgeCount + 1;
            end else if (req1_valid && eR1) begin
                jobActive = 1; jobA = req1_a; jobB = req1_b; jobCin = req1_cin; jobId = 1;
                lastG = 1; acceptEdge = edgeCount + 1;
            end
        end else if (eV && res_ready) begin
            jobActive = 0;
        end
    end

    int capQ[$];
    always @(negedge clk) if (rst_n && res_valid && res_ready) capQ.push_back(int'(res_id));

    int          hsEdge, validEdge;
    logic [15:0] gotSum;
    logic        gotCout, gotId;

    task automatic waitHs(input bit sel);
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (sel ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                got = 1;
                hsEdge = edgeCount;
            end
            @(posedge clk); #1;
        end
        check("handshake_timeout", 32'(got), 32'd1);
    endtask

    task automatic doOne(input bit sel, input logic [15:0] a, input logic [15:0] b, input logic cin);
        if (!sel) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1;
        end
        waitHs(sel);
        if (!sel) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic getResult();
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1; gotSum = res_sum; gotCout = res_cout; gotId = res_id; validEdge = edgeCount;
            end
            @(posedge clk); #1;
        end
        check("result_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          ord[$];
    int          acc, cnt;
    bit          h0, h1;
    logic [15:0] bpA, bpB, bp1A, bp1B;
    logic        bpCin, bp1Cin;
    int          bpExp, bp1Exp;

    initial begin
        rst_n = 0; res_ready = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_slc_a", 32'(slc_a), 32'd0);
        @(posedge clk); #1 rst_n = 1;

        // Single request with known answer
        doOne(0, 16'h1234, 16'h0FFF, 1'b0);
        getResult();
        check("t1_sum", 32'(gotSum), 32'h2233);
        check("t1_cout", 32'(gotCout), 32'd0);
        check("t1_id", 32'(gotId), 32'd0);
        check("t1_latency", 32'(validEdge - hsEdge), 32'd5);

        // Full carry ripple through every nibble
        doOne(1, 16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_slc_cin", 32'(slc_cin), 32'd1);
        end
        getResult();
        check("t2_sum", 32'(gotSum), 32'h0000);
        check("t2_cout", 32'(gotCout), 32'd1);
        check("t2_id", 32'(gotId), 32'd1);

        // Round-robin under constant contention, starting from reset
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        capQ.delete();
        acc = 0;
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom); req0_valid = 1;
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom); req1_valid = 1;
        for (int n = 0; n < 200 && acc < 4; n++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (h0) begin
                ord.push_back(0); acc++;
                req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
            end
            if (h1) begin
                ord.push_back(1); acc++;
                req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
            end
        end
        req0_valid = 0; req1_valid = 0;
        repeat (12) @(posedge clk);
        #1;
        check("t3_accepts", 32'(ord.size()), 32'd4);
        check("t3_results", 32'(capQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_grant_order", 32'(ord[i]), 32'(i % 2));
            check("t3_res_id_order", 32'(capQ[i]), 32'(i % 2));
        end

        // Backpressure in DONE with a waiting requester
        res_ready = 0;
        bpA = 16'($urandom); bpB = 16'($urandom); bpCin = 1'($urandom);
        bpExp = int'(bpA) + int'(bpB) + int'(bpCin);
        doOne(0, bpA, bpB, bpCin);
        bp1A = 16'($urandom); bp1B = 16'($urandom); bp1Cin = 1'($urandom);
        bp1Exp = int'(bp1A) + int'(bp1B) + int'(bp1Cin);
        req1_a = bp1A; req1_b = bp1B; req1_cin = bp1Cin; req1_valid = 1;
        cnt = 0;
        for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(res_valid), 32'd1);
            check("t4_hold_sum", 32'(res_sum), 32'(bpExp & 32'hFFFF));
            check("t4_hold_id", 32'(res_id), 32'd0);
            check("t4_hold_ready0", 32'(req0_ready), 32'd0);
            check("t4_hold_ready1", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 res_ready = 1;
        @(negedge clk);
        check("t4_release_valid", 32'(res_valid), 32'd1);
        @(negedge clk);
        check("t4_after_valid", 32'(res_valid), 32'd0);
        check("t4_after_ready1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1 req1_valid = 0;
        getResult();
        check("t4_req1_sum", 32'(gotSum), 32'(bp1Exp & 32'hFFFF));
        check("t4_req1_cout", 32'(gotCout), 32'((bp1Exp >> 16) & 1));
        check("t4_req1_id", 32'(gotId), 32'd1);

        // Reset during the third RUN cycle aborts the operation
        doOne(0, 16'($urandom), 16'($urandom), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        check("t5_aborted_no_valid", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        doOne(0, 16'h0001, 16'h0001, 1'b0);
        getResult();
        check("t5_sum", 32'(gotSum), 32'h0002);
        check("t5_cout", 32'(gotCout), 32'd0);

        // Idle: slice inputs quiet, no result
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slc_a != 0 || slc_b != 0 || slc_cin || res_valid) cnt++;
        end
        check("t6_idle_quiet", 32'(cnt), 32'd0);

        // Random traffic with withdrawals and random backpressure
        @(posedge clk); #1;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (h0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) == 0);
                req0_a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                req0_b = 16'($urandom); req0_cin = 1'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req0_valid = 0;
            end
            if (h1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) == 0);
                req1_a = 16'($urandom);
                req1_b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                req1_cin = 1'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req1_valid = 0;
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        repeat (12) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
